// File: rtl/burst_cache_pkg.sv
// burst_cache_pkg: shared constants for the burst cache.
//   - line geometry: 8 x 32-bit columns per line, one 4-beat 64-bit burst
//   - FSM state encodings
//   - lane_mask(): places a 4-bit CPU byte enable into a 64-bit beat
package burst_cache_pkg;

  localparam int COLUMN_IX_BITWIDTH   = 3;
  localparam int BURST_BEATS          = 4;
  localparam int BYTE_OFFSET_BITWIDTH = 2;
  localparam int BEAT_IX_BITWIDTH     = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WB_BURST  = 3'd1;
  localparam logic [2:0] ST_FILL_CMD  = 3'd2;
  localparam logic [2:0] ST_FILL_WAIT = 3'd3;
  localparam logic [2:0] ST_COMPLETE  = 3'd4;

  // Odd columns live in the upper half of a beat.
  function automatic logic [7:0] lane_mask(input logic upper, input logic [3:0] we);
    return upper ? {we, 4'b0000} : {4'b0000, we};
  endfunction

endpackage

// File: rtl/burst_cache_store.sv
// burst_cache_store: line state and data storage for burst_cache.
//   meta_*  : registered lookup of valid/dirty/tag for one line index
//   upd_ix  : line touched by fill_done (valid, clean, new tag) or dirty_set
//   data_*  : 64-bit beat-wide data array, one synchronous read port and one
//             byte-enabled write port
// Both read ports are write-first: a write in the same cycle to the entry
// being looked up is visible in the registered result.
module burst_cache_store
  import burst_cache_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH = 8,
  parameter int TAG_BITWIDTH     = 11
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         meta_rd_en,
  input  logic [LINE_IX_BITWIDTH-1:0]                  meta_rd_ix,
  output logic                                         meta_valid,
  output logic                                         meta_dirty,
  output logic [TAG_BITWIDTH-1:0]                      meta_tag,
  input  logic                                         fill_done,
  input  logic                                         dirty_set,
  input  logic [LINE_IX_BITWIDTH-1:0]                  upd_ix,
  input  logic [TAG_BITWIDTH-1:0]                      fill_tag,
  input  logic [LINE_IX_BITWIDTH+BEAT_IX_BITWIDTH-1:0] data_rd_addr,
  output logic [63:0]                                  data_rd,
  input  logic                                         data_wr_en,
  input  logic [LINE_IX_BITWIDTH+BEAT_IX_BITWIDTH-1:0] data_wr_addr,
  input  logic [7:0]                                   data_wr_be,
  input  logic [63:0]                                  data_wr_data
);

  localparam int NUM_LINES = 1 << LINE_IX_BITWIDTH;
  localparam int NUM_WORDS = NUM_LINES * BURST_BEATS;

  logic [NUM_LINES-1:0]    valid_bits;
  logic [NUM_LINES-1:0]    dirty_bits;
  logic [TAG_BITWIDTH-1:0] tag_mem  [NUM_LINES];
  logic [63:0]             data_mem [NUM_WORDS];

  logic fwd_fill;
  logic fwd_dirty;

  assign fwd_fill  = fill_done && (upd_ix == meta_rd_ix);
  assign fwd_dirty = dirty_set && (upd_ix == meta_rd_ix);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
      meta_valid <= 1'b0;
      meta_dirty <= 1'b0;
    end else begin
      if (fill_done) begin
        valid_bits[upd_ix] <= 1'b1;
        dirty_bits[upd_ix] <= 1'b0;
      end
      if (dirty_set) dirty_bits[upd_ix] <= 1'b1;
      if (meta_rd_en) begin
        meta_valid <= valid_bits[meta_rd_ix] | fwd_fill;
        meta_dirty <= (dirty_bits[meta_rd_ix] & ~fwd_fill) | fwd_dirty;
      end
    end
  end

  // NOTE: only valid/dirty need reset; tags and data are never trusted
  // without a valid bit, so the arrays stay reset-free and map onto RAM.
  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[upd_ix] <= fill_tag;
    if (meta_rd_en) meta_tag <= fwd_fill ? fill_tag : tag_mem[meta_rd_ix];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (data_wr_en && data_wr_be[b]) data_mem[data_wr_addr][8*b +: 8] <= data_wr_data[8*b +: 8];
      data_rd[8*b +: 8] <= (data_wr_en && data_wr_be[b] && (data_wr_addr == data_rd_addr))
                           ? data_wr_data[8*b +: 8] : data_mem[data_rd_addr][8*b +: 8];
    end
  end

endmodule

// File: rtl/burst_cache.sv
// burst_cache: direct-mapped, write-back, write-allocate cache between a
// 32-bit CPU port and a 64-bit, 4-beat burst RAM.
//   clk, rst (sync, active high)
//   CPU : address, data_in, write_enable (0 = read) -> data_out,
//         data_out_ready, busy (miss in progress, hold the request)
//   RAM : br_cmd (1 = write), br_cmd_en, br_addr (64-bit word address),
//         br_wr_data, br_data_mask (always 0) <- br_rd_data, br_rd_data_valid
// The request is looked up at every edge while idle; the hit/miss decision is
// made in the following cycle from the registered lookup.
module burst_cache
  import burst_cache_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH         = 8,
  parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
  parameter int RAM_ADDRESSING           = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         address,
  output logic [31:0]                         data_out,
  output logic                                data_out_ready,
  input  logic [31:0]                         data_in,
  input  logic [3:0]                          write_enable,
  output logic                                busy,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                         br_wr_data,
  output logic [7:0]                          br_data_mask,
  input  logic [63:0]                         br_rd_data,
  input  logic                                br_rd_data_valid
);

  localparam int LINE_LSB     = BYTE_OFFSET_BITWIDTH + COLUMN_IX_BITWIDTH;
  localparam int TAG_LSB      = LINE_LSB + LINE_IX_BITWIDTH;
  localparam int TAG_BITWIDTH = BURST_RAM_DEPTH_BITWIDTH + RAM_ADDRESSING - TAG_LSB;
  localparam int DATA_ADDR_BITWIDTH = LINE_IX_BITWIDTH + BEAT_IX_BITWIDTH;

  // CPU address fields; a column is a beat index plus a half select.
  logic [LINE_IX_BITWIDTH-1:0] cpu_ix;
  logic [BEAT_IX_BITWIDTH-1:0] cpu_beat;
  logic                        cpu_upper;
  logic [TAG_BITWIDTH-1:0]     cpu_tag;
  logic                        unused_addr_bits;

  assign cpu_ix    = address[TAG_LSB-1:LINE_LSB];
  assign cpu_beat  = address[LINE_LSB-1:RAM_ADDRESSING];
  assign cpu_upper = address[RAM_ADDRESSING-1];
  assign cpu_tag   = address[TAG_LSB +: TAG_BITWIDTH];
  assign unused_addr_bits = ^{address[RAM_ADDRESSING-2:0], address[31:TAG_LSB+TAG_BITWIDTH]};

  // Request as captured with the lookup.
  logic [LINE_IX_BITWIDTH-1:0] req_ix;
  logic [BEAT_IX_BITWIDTH-1:0] req_beat;
  logic                        req_upper;
  logic [TAG_BITWIDTH-1:0]     req_tag;
  logic [3:0]                  req_we;
  logic [31:0]                 req_data;
  logic                        req_live;

  logic [2:0]                  state;
  logic [2:0]                  next_state;
  logic [BEAT_IX_BITWIDTH-1:0] beat_cnt;
  logic [31:0]                 fill_word;

  logic                          meta_valid;
  logic                          meta_dirty;
  logic [TAG_BITWIDTH-1:0]       meta_tag;
  logic [63:0]                   data_rd;
  logic [DATA_ADDR_BITWIDTH-1:0] data_rd_addr;
  logic                          wr_en;
  logic [DATA_ADDR_BITWIDTH-1:0] wr_addr;
  logic [7:0]                    wr_be;
  logic [63:0]                   wr_data;

  logic idle_eval, hit, miss, write_hit, read_hit;
  logic complete_read, complete_write;
  logic last_beat, beat_step, fill_beat, fill_done, capture;

  assign idle_eval      = (state == ST_IDLE) && req_live;
  assign hit            = meta_valid && (meta_tag == req_tag);
  assign miss           = idle_eval && !hit;
  assign read_hit       = idle_eval && hit && (req_we == 4'b0000);
  assign write_hit      = idle_eval && hit && (req_we != 4'b0000);
  assign complete_read  = (state == ST_COMPLETE) && (req_we == 4'b0000);
  assign complete_write = (state == ST_COMPLETE) && (req_we != 4'b0000);
  assign last_beat      = beat_cnt == BEAT_IX_BITWIDTH'(BURST_BEATS - 1);
  assign fill_beat      = (state == ST_FILL_WAIT) && br_rd_data_valid;
  assign fill_done      = fill_beat && last_beat && !rst;
  assign beat_step      = (state == ST_WB_BURST) || fill_beat;
  // A fresh lookup is taken on every edge that lands in IDLE.
  assign capture        = next_state == ST_IDLE;

  // NOTE: every output of this always_comb gets a default first, so no
  // path through the case can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (miss) next_state = (meta_valid && meta_dirty) ? ST_WB_BURST : ST_FILL_CMD;
      ST_WB_BURST:  if (last_beat) next_state = ST_FILL_CMD;
      ST_FILL_CMD:  next_state = ST_FILL_WAIT;
      ST_FILL_WAIT: if (br_rd_data_valid && last_beat) next_state = ST_COMPLETE;
      ST_COMPLETE:  next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      req_live <= 1'b0;
    end else begin
      state    <= next_state;
      req_live <= capture;
      if (beat_step) beat_cnt <= beat_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      req_ix    <= cpu_ix;
      req_beat  <= cpu_beat;
      req_upper <= cpu_upper;
      req_tag   <= cpu_tag;
      req_we    <= write_enable;
      req_data  <= data_in;
    end
    // Keep the requested column as it streams past so COMPLETE can return it.
    if (fill_beat && (beat_cnt == req_beat))
      fill_word <= req_upper ? br_rd_data[63:32] : br_rd_data[31:0];
  end

  // Read port: victim beat 0 is fetched on the miss-detect edge so it is on
  // br_wr_data alongside the write command; later beats are prefetched one
  // ahead of the burst counter.
  always_comb begin
    data_rd_addr = {cpu_ix, cpu_beat};
    if (miss)                          data_rd_addr = {req_ix, {BEAT_IX_BITWIDTH{1'b0}}};
    else if (state == ST_WB_BURST)     data_rd_addr = {req_ix, beat_cnt + 2'd1};
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {req_ix, req_beat};
    wr_be   = lane_mask(req_upper, req_we);
    wr_data = {req_data, req_data};
    if (write_hit || complete_write) begin
      wr_en = 1'b1;
    end else if (fill_beat) begin
      wr_en   = 1'b1;
      wr_addr = {req_ix, beat_cnt};
      wr_be   = 8'hFF;
      wr_data = br_rd_data;
    end
  end

  burst_cache_store #(
    .LINE_IX_BITWIDTH (LINE_IX_BITWIDTH),
    .TAG_BITWIDTH     (TAG_BITWIDTH)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .meta_rd_en   (capture),
    .meta_rd_ix   (cpu_ix),
    .meta_valid   (meta_valid),
    .meta_dirty   (meta_dirty),
    .meta_tag     (meta_tag),
    .fill_done    (fill_done),
    .dirty_set    (write_hit || complete_write),
    .upd_ix       (req_ix),
    .fill_tag     (req_tag),
    .data_rd_addr (data_rd_addr),
    .data_rd      (data_rd),
    .data_wr_en   (wr_en && !rst),
    .data_wr_addr (wr_addr),
    .data_wr_be   (wr_be),
    .data_wr_data (wr_data)
  );

  assign busy           = miss || (state == ST_WB_BURST) || (state == ST_FILL_CMD) ||
                          (state == ST_FILL_WAIT);
  assign data_out_ready = read_hit || complete_read;
  assign data_out       = (state == ST_COMPLETE) ? fill_word
                                                 : (req_upper ? data_rd[63:32] : data_rd[31:0]);

  assign br_cmd       = state == ST_WB_BURST;
  assign br_cmd_en    = ((state == ST_WB_BURST) && (beat_cnt == '0)) || (state == ST_FILL_CMD);
  assign br_addr      = (state == ST_WB_BURST) ? {meta_tag, req_ix, {BEAT_IX_BITWIDTH{1'b0}}}
                                               : {req_tag,  req_ix, {BEAT_IX_BITWIDTH{1'b0}}};
  assign br_wr_data   = data_rd;
  assign br_data_mask = 8'h00;

endmodule

// File: tb/tb_burst_cache.sv
// tb_burst_cache: directed bench for burst_cache with 2 lines and a 16-word
// burst RAM modelled inline (write beats accepted from the command cycle,
// read beats 6 cycles after the command).
module tb_burst_cache;

  localparam int LINE_IX_BITWIDTH = 1;
  localparam int DEPTH_BITWIDTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic [31:0] data_in;
  logic [3:0]  write_enable;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [DEPTH_BITWIDTH-1:0] br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data = 64'h0;
  logic        br_rd_data_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  burst_cache #(
    .LINE_IX_BITWIDTH         (LINE_IX_BITWIDTH),
    .BURST_RAM_DEPTH_BITWIDTH (DEPTH_BITWIDTH),
    .RAM_ADDRESSING           (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .address          (address),
    .data_out         (data_out),
    .data_out_ready   (data_out_ready),
    .data_in          (data_in),
    .write_enable     (write_enable),
    .busy             (busy),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid)
  );

  // Burst RAM model, preloaded: bytes 8/12 -> word 1, 16 -> word 2, 32 -> word 4.
  logic [63:0] ram [16] = '{1: 64'h9D8E2F17_AB4C3E6F, 2: 64'h00000000_D5B8A9C4,
                            4: 64'h00000000_2F5E3C7A, default: 64'h0};
  int   rd_timer = 0;
  int   wb_beat  = 0;
  logic [DEPTH_BITWIDTH-1:0] rd_base = '0;
  logic [DEPTH_BITWIDTH-1:0] wb_base = '0;
  logic [DEPTH_BITWIDTH-1:0] last_wb_addr = '1;
  logic [DEPTH_BITWIDTH-1:0] last_fill_addr = '1;
  int   cmd_count = 0;
  int   wb_count  = 0;
  logic ram_busy;

  assign ram_busy = (rd_timer != 0) || (wb_beat != 0);

  always @(posedge clk) begin
    br_rd_data_valid <= 1'b0;
    if (br_cmd_en) cmd_count <= cmd_count + 1;
    if (br_cmd_en && br_cmd) begin
      ram[br_addr] <= br_wr_data;
      wb_base      <= br_addr;
      wb_beat      <= 1;
      wb_count     <= wb_count + 1;
      last_wb_addr <= br_addr;
    end else if (wb_beat != 0) begin
      ram[wb_base + 4'(wb_beat)] <= br_wr_data;
      wb_beat <= (wb_beat == 3) ? 0 : wb_beat + 1;
    end
    if (br_cmd_en && !br_cmd) begin
      rd_base        <= br_addr;
      rd_timer       <= 1;
      last_fill_addr <= br_addr;
    end else if (rd_timer != 0) begin
      if (rd_timer >= 6) begin
        br_rd_data_valid <= 1'b1;
        br_rd_data       <= ram[rd_base + 4'(rd_timer - 6)];
      end
      rd_timer <= (rd_timer == 9) ? 0 : rd_timer + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Applies a request at a negedge and returns at the first negedge with
  // busy low, reporting what the first evaluation cycle looked like.
  task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                        output bit was_busy, output bit first_ready);
    address      = a;
    write_enable = we;
    data_in      = din;
    @(negedge clk);
    was_busy    = busy;
    first_ready = data_out_ready;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) check("busy_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit was_busy, first_ready, seen;
    int snap_cmd, snap_wb;

    rst = 1'b1; address = '0; write_enable = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ready", 64'(data_out_ready), 64'd0);
    check("rst_cmden", 64'(br_cmd_en), 64'd0);
    check("rst_cmd",   64'(br_cmd), 64'd0);
    check("rst_mask",  64'(br_data_mask), 64'd0);
    rst = 1'b0;

    do_req(32'd16, 4'b0000, 32'h0, was_busy, first_ready);
    check("cold16_busy",   64'(was_busy), 64'd1);
    check("cold16_first",  64'(first_ready), 64'd0);
    check("cold16_ready",  64'(data_out_ready), 64'd1);
    check("cold16_data",   64'(data_out), 64'hD5B8A9C4);
    check("cold16_fill",   64'(last_fill_addr), 64'd0);

    do_req(32'd8, 4'b0000, 32'h0, was_busy, first_ready);
    check("hit8_busy",  64'(was_busy), 64'd0);
    check("hit8_ready", 64'(data_out_ready), 64'd1);
    check("hit8_data",  64'(data_out), 64'hAB4C3E6F);

    do_req(32'd32, 4'b0000, 32'h0, was_busy, first_ready);
    check("miss32_busy",  64'(was_busy), 64'd1);
    check("miss32_first", 64'(first_ready), 64'd0);
    check("miss32_ready", 64'(data_out_ready), 64'd1);
    check("miss32_data",  64'(data_out), 64'h2F5E3C7A);
    check("miss32_fill",  64'(last_fill_addr), 64'd4);

    do_req(32'd12, 4'b0000, 32'h0, was_busy, first_ready);
    check("hit12_busy", 64'(was_busy), 64'd0);
    check("hit12_data", 64'(data_out), 64'h9D8E2F17);

    do_req(32'd8, 4'b0001, 32'h000000AD, was_busy, first_ready);
    check("wr8a_busy",  64'(was_busy), 64'd0);
    check("wr8a_ready", 64'(first_ready), 64'd0);
    do_req(32'd8, 4'b0000, 32'h0, was_busy, first_ready);
    check("rd8a_data",  64'(data_out), 64'hAB4C3EAD);

    do_req(32'd8, 4'b0011, 32'h00008765, was_busy, first_ready);
    do_req(32'd8, 4'b0000, 32'h0, was_busy, first_ready);
    check("rd8b_data",  64'(data_out), 64'hAB4C8765);

    do_req(32'd8, 4'b1100, 32'hFEEF0000, was_busy, first_ready);
    do_req(32'd8, 4'b0000, 32'h0, was_busy, first_ready);
    check("rd8c_ready", 64'(data_out_ready), 64'd1);
    check("rd8c_data",  64'(data_out), 64'hFEEF8765);

    snap_wb = wb_count;
    do_req(32'd64, 4'b1111, 32'hABCDEF12, was_busy, first_ready);
    check("wr64_busy",    64'(was_busy), 64'd1);
    check("wr64_ready",   64'(data_out_ready), 64'd0);
    check("wr64_wbcount", 64'(wb_count - snap_wb), 64'd1);
    check("wr64_wbaddr",  64'(last_wb_addr), 64'd0);
    check("wr64_fill",    64'(last_fill_addr), 64'd8);
    check("wr64_wbdata",  ram[1], 64'h9D8E2F17_FEEF8765);
    check("wr64_wbdata2", ram[2], 64'h00000000_D5B8A9C4);

    do_req(32'd64, 4'b0000, 32'h0, was_busy, first_ready);
    check("rd64a_busy", 64'(was_busy), 64'd0);
    check("rd64a_data", 64'(data_out), 64'hABCDEF12);

    do_req(32'd64, 4'b1111, 32'h1B2D3F42, was_busy, first_ready);
    check("wr64b_busy", 64'(was_busy), 64'd0);
    do_req(32'd64, 4'b0000, 32'h0, was_busy, first_ready);
    check("rd64b_data", 64'(data_out), 64'h1B2D3F42);

    // Reset while waiting for fill beats of a dirty-victim read miss.
    seen = 1'b0;
    address = 32'd16; write_enable = 4'b0000;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (br_cmd_en && !br_cmd) seen = 1'b1;
    end
    check("mid_fill_cmd_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",  64'(busy), 64'd0);
    check("mid_rst_cmden", 64'(br_cmd_en), 64'd0);
    snap_cmd = cmd_count;
    for (int i = 0; i < 50 && ram_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("mid_rst_no_cmd", 64'(cmd_count - snap_cmd), 64'd0);
    check("mid_rst_wbdata", ram[8], 64'h00000000_1B2D3F42);
    rst = 1'b0;

    snap_wb = wb_count;
    do_req(32'd16, 4'b0000, 32'h0, was_busy, first_ready);
    check("post_rst_busy",  64'(was_busy), 64'd1);
    check("post_rst_ready", 64'(data_out_ready), 64'd1);
    check("post_rst_data",  64'(data_out), 64'hD5B8A9C4);
    check("post_rst_no_wb", 64'(wb_count - snap_wb), 64'd0);
    check("post_rst_cmds",  64'(cmd_count - snap_cmd), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
